// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction fetch PC owner with a small {pc, inst} FIFO toward decode
//
// Ports:
//   clk, clrn              clock and asynchronous active-low reset
//   imem_a / imem_inst     ROM word address (the fetch PC) and its same-cycle data
//   redirect, redirect_pc  flush the FIFO and restart fetch at redirect_pc (low two bits dropped)
//   out_valid/out_ready    decode handshake for the FIFO head
//   out_inst, out_pc       FIFO head contents; driven 0 while empty
//   count                  current FIFO occupancy
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     clrn,
    output logic [31:0]              imem_a,
    input  logic [31:0]              imem_inst,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   pc_mem_d   [DEPTH];
    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   inst_mem_d [DEPTH];

    logic not_empty;
    logic pop;
    logic push;

    assign not_empty = (count_q != '0);
    assign pop       = not_empty & out_ready;
    // A full FIFO can still accept a word when the head leaves in the same cycle.
    assign push      = !redirect & ((count_q < CW'(DEPTH)) | pop);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;

        if (redirect) begin
            // Redirect squashes everything, including a pop decode may have seen.
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push) begin
                pc_mem_d[wr_ptr_q]   = fetch_pc_q;
                inst_mem_d[wr_ptr_q] = imem_inst;
                wr_ptr_d             = wr_ptr_q + PW'(1);
                fetch_pc_d           = fetch_pc_q + 32'd4;
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            pc_mem_q   <= pc_mem_d;
            inst_mem_q <= inst_mem_d;
        end
    end

    // Outputs come only from storage, never from imem_inst.
    assign imem_a    = fetch_pc_q;
    assign count     = count_q;
    assign out_valid = not_empty;
    assign out_pc    = not_empty ? pc_mem_q[rd_ptr_q]   : 32'h0;
    assign out_inst  = not_empty ? inst_mem_q[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed and randomized bench for inst_fetch_queue against a queue model
module tb_inst_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] imem_a;
    logic [31:0] imem_inst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [$clog2(DEPTH):0] count;

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .imem_a      (imem_a),
        .imem_inst   (imem_inst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .count       (count)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [256];

    function automatic logic [31:0] rom_rd(input logic [31:0] a);
        logic [7:0] idx;
        idx = 8'(a >> 2);
        return rom[idx];
    endfunction

    always_comb imem_inst = rom_rd(imem_a);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fpc;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc = RESET_PC;
    endtask

    task automatic check_all(input string tag);
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einst;
        ev    = (mq.size() != 0);
        epc   = ev ? mq[0].pc   : 32'h0;
        einst = ev ? mq[0].inst : 32'h0;
        chk({tag, "_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, "_count"}, 32'(count), 32'(mq.size()));
        chk({tag, "_imem_a"}, imem_a, m_fpc);
        chk({tag, "_pc"}, out_pc, epc);
        chk({tag, "_inst"}, out_inst, einst);
    endtask

    // One clock: drive inputs at the falling edge, step the model at the rising
    // edge, then compare everything at the next falling edge.
    task automatic cycle(input logic r, input logic [31:0] rpc, input logic rdy, input string tag);
        logic pop;
        logic push;
        redirect    = r;
        redirect_pc = rpc;
        out_ready   = rdy;
        pop  = (mq.size() != 0) && rdy;
        push = !r && ((mq.size() < DEPTH) || pop);
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_fpc = {rpc[31:2], 2'b00};
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back('{pc: m_fpc, inst: rom_rd(m_fpc)});
                m_fpc = m_fpc + 32'd4;
            end
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rom[0]  = 32'h0040_0493;
        rom[1]  = 32'h0100_4457;
        rom[5]  = 32'h0000_0000;
        rom[23] = 32'h0210_00DB;

        clrn        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        clrn = 1'b1;

        // Streaming from reset with decode always ready.
        out_ready = 1'b1;
        cycle(1'b0, 32'h0, 1'b1, "t1");
        chk("t1_first_inst", out_inst, 32'h0040_0493);
        cycle(1'b0, 32'h0, 1'b1, "t1");
        chk("t1_second_pc", out_pc, 32'h0000_0004);
        chk("t1_second_inst", out_inst, 32'h0100_4457);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, "t1_stream");

        // Back-pressure: fill, saturate, then drain.
        model_reset();
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 32'h0, 1'b0, "t2_fill");
            chk("t2_count_seq", 32'(count), (i < 4) ? i + 1 : 4);
        end
        chk("t2_imem_freeze", imem_a, 32'h0000_0010);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, "t2_drain");

        // Full FIFO with a single ready cycle.
        cycle(1'b1, 32'h0, 1'b0, "t3_redir");
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0, "t3_fill");
        cycle(1'b0, 32'h0, 1'b1, "t3_swap");
        chk("t3_count", 32'(count), 32'd4);
        chk("t3_head", out_pc, 32'h0000_0004);
        chk("t3_fetch", imem_a, 32'h0000_0014);

        // Redirect to the loop back-edge with three entries buffered.
        cycle(1'b1, 32'h0, 1'b0, "t4_redir0");
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, "t4_fill");
        chk("t4_count3", 32'(count), 32'd3);
        cycle(1'b1, 32'h0000_005C, 1'b0, "t4_redir");
        chk("t4_empty", 32'(out_valid), 32'd0);
        chk("t4_imem_a", imem_a, 32'h0000_005C);
        cycle(1'b0, 32'h0, 1'b0, "t4_first");
        chk("t4_pc", out_pc, 32'h0000_005C);
        chk("t4_inst", out_inst, 32'h0210_00DB);

        // Misaligned redirect while full and popping, then back-to-back redirect.
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, "t5_fill");
        chk("t5_full", 32'(count), 32'd4);
        cycle(1'b1, 32'h0000_005E, 1'b1, "t5_redir");
        chk("t5_align", imem_a, 32'h0000_005C);
        chk("t5_count", 32'(count), 32'd0);
        cycle(1'b1, 32'h0, 1'b1, "t5_redir2");
        cycle(1'b0, 32'h0, 1'b1, "t5_after");
        chk("t5_pc0", out_pc, 32'h0000_0000);
        cycle(1'b0, 32'h0, 1'b1, "t5_after");
        chk("t5_pc4", out_pc, 32'h0000_0004);

        // Asynchronous reset mid-cycle with two entries buffered.
        cycle(1'b1, 32'h0000_0040, 1'b0, "t6_redir");
        cycle(1'b0, 32'h0, 1'b0, "t6_fill");
        cycle(1'b0, 32'h0, 1'b0, "t6_fill");
        chk("t6_count2", 32'(count), 32'd2);
        #2;
        clrn = 1'b0;
        #1;
        model_reset();
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_count", 32'(count), 32'd0);
        @(negedge clk);
        check_all("t6_held");
        clrn = 1'b1;
        cycle(1'b0, 32'h0, 1'b1, "t6_release");
        chk("t6_reset_pc", out_pc, RESET_PC);

        // Randomized traffic against the model, including wrap-around targets.
        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 1023));
            cycle(r, rpc, ($urandom_range(0, 3) != 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction-fetch front end placed between the PC and the instruction ROM on one side, and the RV32IMV decode stage on the other.
- Owns the fetch PC and drives the ROM word address. The ROM returns `inst` combinationally in the same cycle.
- Each fetched {pc, inst} pair is buffered in a small FIFO. Decode pops entries with a valid/ready handshake.
- A redirect from branch/jump resolution (e.g. loop back-edges, `jr ra`) flushes the FIFO and restarts fetch at the target.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, fetch PC after reset; must be word-aligned.

Ports:
- clk  input  1  rising-edge clock.
- clrn  input  1  asynchronous active-low reset.
- imem_a  output  32  ROM address; equals fetch_pc.
- imem_inst  input  32  ROM data for imem_a, valid in the same cycle.
- redirect  input  1  flush request from execute.
- redirect_pc  input  32  restart address; bits [1:0] are ignored.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  decode accepts the head this cycle.
- out_inst  output  32  instruction at the head.
- out_pc  output  32  PC of out_inst.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (clrn=0, asynchronous):
  - fetch_pc=RESET_PC, count=0, read/write pointers=0.
  - out_valid=0, out_inst=0, out_pc=0.
  - Takes effect immediately, including mid-operation; all buffered entries are discarded.
- Handshake signals:
  - pop = out_valid & out_ready.
  - push = !redirect & (count<DEPTH | pop).
- Push (at the clock edge):
  - Write {fetch_pc, imem_inst} at the write pointer.
  - fetch_pc <= fetch_pc+4. Wraps modulo 2^32; no overflow flag.
- Pop: read pointer advances. Pointers wrap modulo DEPTH.
- Occupancy update:
  - push & !pop: count+1.
  - pop & !push: count-1.
  - both: count unchanged.
- Full (count==DEPTH):
  - No push unless a pop occurs in the same cycle.
  - fetch_pc and imem_a hold.
- Empty (count==0):
  - out_valid=0; out_inst and out_pc are driven 0.
  - A pop cannot occur. A push makes the entry visible on the following cycle.
- Latency:
  - Fetch-to-output is 1 cycle. Entries become visible on the cycle after the push edge.
  - Steady-state throughput is 1 instruction/cycle when out_ready=1.
- Output timing: out_valid, out_inst and out_pc are taken from FIFO storage at the read pointer. There is no combinational path from imem_inst to any output.
- Redirect (highest priority, overrides push and pop):
  - count<=0, pointers<=0.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - Any pop the decode stage sees in that cycle is treated as not having occurred; decode must ignore it because the instruction is squashed.
  - The first instruction from the new target is fetched the next cycle and becomes valid the cycle after that (2-cycle redirect bubble).
- Back-to-back redirects: each redirect restarts fetch; only the last target is fetched.
- Data rule: imem_inst is never interpreted. All-zero words are buffered like any other word.
- State is pointer/counter based; there is no separate FSM beyond {EMPTY, PARTIAL, FULL}, which is derived from count.

Test Plan:
1. Reset release with out_ready=1 and the AES key-schedule ROM loaded:
   - Cycle 1: out_valid=1, out_pc=0x00, out_inst=32'h00400493.
   - Cycle 2: out_pc=0x04, out_inst=32'h01004457.
   - pc then increments by 4 every cycle with no bubbles.
2. Hold out_ready=0 after reset:
   - count rises 1,2,3,4 and then saturates at 4.
   - imem_a freezes at 0x10.
   - Raising out_ready then drains pcs 0x00,0x04,0x08,0x0C,0x10,0x14 in order.
3. Full FIFO with out_ready=1 for one cycle:
   - Simultaneous pop and push; count stays 4.
   - Head advances 0x00→0x04; fetch_pc goes 0x10→0x14.
4. Redirect to 0x5C (encrypt loop back-edge) with 3 entries buffered:
   - Next cycle: count=0, out_valid=0, imem_a=0x5C.
   - Following cycle: out_pc=0x5C, out_inst=32'h0210_00DB.
5. Redirect with redirect_pc=0x5E while out_ready=1 and the FIFO is full:
   - Fetch restarts at 0x5C, and the popped head is discarded.
   - A second redirect to 0x00 on the next cycle leaves only pc 0x00 fetched.
6. Assert clrn=0 asynchronously mid-cycle with count=2:
   - out_valid falls immediately, count=0.
   - After release, the next output pc is RESET_PC.
